arashi_dispatch: RTL and testbench

- Return-path counterpart of the thread cache/arbiter write path.
- Accepts a single tagged response stream from memory and demultiplexes each word, by thread id, into a small per-thread FIFO.
- Each thread drains its own FIFO with a valid/ready handshake.
- Sits between the memory response port and the per-thread consumers. Per-thread backpressure goes onto the shared memory stream.

---
 rtl/arashi_pkg.sv | 19 +
 rtl/arashi_thread_fifo.sv | 75 +++++++
 rtl/arashi_dispatch.sv | 59 +++++
 tb/tb_arashi_dispatch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arashi_pkg.sv
// Shared definitions for the arashi thread cache/arbiter and its return-path
// dispatcher: thread count derivation and the common word/thread-id types.
package arashi_pkg;

    localparam int ARASHI_DATA_WIDTH       = 32;
    localparam int ARASHI_THREAD_NUM_WIDTH = 2;
    localparam int ARASHI_DEPTH_WIDTH      = 1;

    // Number of threads addressed by a thread id of the given width.
    function automatic int thread_count(input int tid_width);
        return 1 << tid_width;
    endfunction

    localparam int ARASHI_THREAD_NUM = thread_count(ARASHI_THREAD_NUM_WIDTH);

    typedef logic [ARASHI_THREAD_NUM_WIDTH-1:0] tid_t;
    typedef logic [ARASHI_DATA_WIDTH-1:0]       data_t;

endpackage

// File: rtl/arashi_thread_fifo.sv
// Small per-thread FIFO. The head word is read straight from the storage
// array so a word pushed into an empty FIFO is visible on the next cycle.
// A full FIFO never accepts a push, even when popped in the same cycle.
module arashi_thread_fifo
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH  = ARASHI_DATA_WIDTH,
    parameter int DEPTH_WIDTH = ARASHI_DEPTH_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WIDTH:0]   count_q,  count_d;
    logic                   push_ok;
    logic                   pop_ok;

    // Word storage; deliberately not reset, only pointers/count are.
    logic [DATA_WIDTH-1:0]  store_q [DEPTH];

    assign full      = (count_q == (DEPTH_WIDTH+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = store_q[rd_ptr_q];

    // Pointer and occupancy update; push is judged on the pre-pop count.
    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write at the current write pointer.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            store_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/arashi_dispatch.sv
// Return-path dispatcher: demultiplexes one tagged memory response stream
// into per-thread FIFOs, each drained by its own valid/ready consumer.
// Backpressure for the addressed thread is presented on mem_ready.
module arashi_dispatch
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH       = ARASHI_DATA_WIDTH,
    parameter int THREAD_NUM_WIDTH = ARASHI_THREAD_NUM_WIDTH,
    parameter int DEPTH_WIDTH      = ARASHI_DEPTH_WIDTH,
    parameter int THREAD_NUM       = thread_count(THREAD_NUM_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             mem_valid,
    input  logic [THREAD_NUM_WIDTH-1:0]      mem_tid,
    input  logic [DATA_WIDTH-1:0]            mem_data,
    output logic                             mem_ready,
    input  logic [THREAD_NUM-1:0]            t_ready,
    output logic [THREAD_NUM-1:0]            t_valid,
    output logic [DATA_WIDTH*THREAD_NUM-1:0] data_out,
    output logic                             busy
);

    logic [THREAD_NUM-1:0] full_vec;
    logic [THREAD_NUM-1:0] empty_vec;
    logic [THREAD_NUM-1:0] push_vec;
    logic                  accept;

    // Readiness depends only on the addressed thread's registered count.
    always_comb begin
        mem_ready = ~full_vec[mem_tid];
        accept    = mem_valid & mem_ready;
    end

    // Activity flag derived purely from registered FIFO state.
    always_comb begin
        busy    = |(~empty_vec);
        t_valid = ~empty_vec;
    end

    for (genvar gi = 0; gi < THREAD_NUM; gi++) begin : g_thread
        assign push_vec[gi] = accept & (mem_tid == THREAD_NUM_WIDTH'(gi));

        arashi_thread_fifo #(
            .DATA_WIDTH  (DATA_WIDTH),
            .DEPTH_WIDTH (DEPTH_WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rstn      (rstn),
            .push      (push_vec[gi]),
            .push_data (mem_data),
            .pop       (t_ready[gi]),
            .full      (full_vec[gi]),
            .empty     (empty_vec[gi]),
            .head_data (data_out[DATA_WIDTH*gi +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_arashi_dispatch.sv
// Testbench for arashi_dispatch: directed scenarios followed by random
// traffic, all compared against per-thread queues of expected words.
module tb_arashi_dispatch;
    import arashi_pkg::*;

    localparam int DW    = 32;
    localparam int TN    = 4;
    localparam int DEPTH = 2;

    logic           clk;
    logic           rstn;
    logic           mem_valid;
    tid_t           mem_tid;
    logic [DW-1:0]  mem_data;
    logic           mem_ready;
    logic [TN-1:0]  t_ready;
    logic [TN-1:0]  t_valid;
    logic [DW*TN-1:0] data_out;
    logic           busy;

    int tests;
    int fails;

    logic [DW-1:0] mq [TN][$];

    arashi_dispatch #(
        .DATA_WIDTH       (32),
        .THREAD_NUM_WIDTH (2),
        .DEPTH_WIDTH      (1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mem_valid (mem_valid),
        .mem_tid   (mem_tid),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .t_ready   (t_ready),
        .t_valid   (t_valid),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue model (state is stable here).
    task automatic check_outputs();
        logic [TN-1:0] exp_tv;
        for (int i = 0; i < TN; i++) begin
            exp_tv[i] = (mq[i].size() != 0);
            tests++;
            assert (mq[i].size() <= DEPTH) else begin
                fails++;
                $error("FAIL model_depth observed=%0d expected<=%0d", mq[i].size(), DEPTH);
            end
        end
        chk("t_valid", DW'(t_valid), DW'(exp_tv));
        chk("busy", DW'(busy), DW'(|exp_tv));
        chk("mem_ready", DW'(mem_ready), DW'(mq[mem_tid].size() < DEPTH));
        for (int i = 0; i < TN; i++) begin
            if (exp_tv[i]) chk($sformatf("data_out%0d", i), data_out[DW*i +: DW], mq[i][0]);
        end
    endtask

    // One clock cycle: drive, check, then advance the model at the edge.
    task automatic step(input logic v, input tid_t tid, input logic [DW-1:0] d, input logic [TN-1:0] rdy);
        bit acc;
        mem_valid = v;
        mem_tid   = tid;
        mem_data  = d;
        t_ready   = rdy;
        #1;
        if (rstn) check_outputs();
        acc = v && (mq[tid].size() < DEPTH);
        @(posedge clk);
        if (!rstn) begin
            for (int i = 0; i < TN; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < TN; i++) begin
                if (rdy[i] && mq[i].size() != 0) void'(mq[i].pop_front());
            end
            if (acc) mq[tid].push_back(d);
        end
        @(negedge clk);
        $display("[TB] t=%0t v=%0b tid=%0d data=%h rdy=%b acc=%0b t_valid=%b busy=%0b",
                 $time, v, tid, d, rdy, acc, t_valid, busy);
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0);
        rstn = 1'b1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rstn      = 1'b0;
        mem_valid = 1'b0;
        mem_tid   = '0;
        mem_data  = '0;
        t_ready   = '0;
        @(negedge clk);

        // 1: reset then idle, mem_ready for every tid
        do_reset(2);
        for (int i = 0; i < TN; i++) step(1'b0, tid_t'(i), 32'hDEAD_BEEF, '0);
        chk("tp1_tvalid", DW'(t_valid), 32'd0);
        chk("tp1_busy", DW'(busy), 32'd0);

        // 2: single push to tid 2, then one pop
        step(1'b1, 2'd2, 32'hA5A5_A5A5, 4'b0000);
        chk("tp2_tvalid", DW'(t_valid), 32'h4);
        chk("tp2_data", data_out[95:64], 32'hA5A5_A5A5);
        step(1'b0, 2'd0, '0, 4'b0100);
        chk("tp2_tvalid_after_pop", DW'(t_valid), 32'h0);
        chk("tp2_busy_after_pop", DW'(busy), 32'd0);

        // 3: fill tid 1, refused third push, ordered drain
        step(1'b1, 2'd1, 32'h11, 4'b0000);
        step(1'b1, 2'd1, 32'h22, 4'b0000);
        mem_tid = 2'd1; #1;
        chk("tp3_ready_full", DW'(mem_ready), 32'd0);
        mem_tid = 2'd0; #1;
        chk("tp3_ready_other", DW'(mem_ready), 32'd1);
        step(1'b1, 2'd1, 32'h33, 4'b0000);
        chk("tp3_head0", data_out[63:32], 32'h11);
        step(1'b0, 2'd0, '0, 4'b0010);
        chk("tp3_head1", data_out[63:32], 32'h22);
        step(1'b0, 2'd0, '0, 4'b0010);
        chk("tp3_drained", DW'(t_valid), 32'h0);

        // 4: full tid 3, push with simultaneous pop is refused
        step(1'b1, 2'd3, 32'h3000_0001, 4'b0000);
        step(1'b1, 2'd3, 32'h3000_0002, 4'b0000);
        step(1'b1, 2'd3, 32'h3000_0003, 4'b1000);
        chk("tp4_head", data_out[127:96], 32'h3000_0002);
        step(1'b0, 2'd0, '0, 4'b1000);
        chk("tp4_empty", DW'(t_valid), 32'h0);

        // 5: interleaved stream with all consumers ready
        step(1'b1, 2'd0, 32'd1, 4'b1111);
        step(1'b1, 2'd1, 32'd2, 4'b1111);
        step(1'b1, 2'd0, 32'd3, 4'b1111);
        step(1'b1, 2'd1, 32'd4, 4'b1111);
        step(1'b1, 2'd2, 32'd5, 4'b1111);
        step(1'b1, 2'd3, 32'd6, 4'b1111);
        step(1'b0, 2'd0, '0, 4'b1111);
        step(1'b0, 2'd0, '0, 4'b1111);

        // 6: reset mid-operation discards buffered words
        step(1'b1, 2'd0, 32'hC0, 4'b0000);
        step(1'b1, 2'd0, 32'hC1, 4'b0000);
        step(1'b1, 2'd3, 32'hC3, 4'b0000);
        do_reset(1);
        chk("tp6_tvalid", DW'(t_valid), 32'h0);
        chk("tp6_busy", DW'(busy), 32'd0);
        step(1'b1, 2'd0, 32'hC5, 4'b0000);
        chk("tp6_new_head", data_out[31:0], 32'hC5);
        step(1'b0, 2'd0, '0, 4'b0001);
        chk("tp6_single", DW'(t_valid), 32'h0);

        // Random traffic, including idle cycles with random tid/data
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 99) < 70), tid_t'($urandom_range(0, TN-1)),
                 32'($urandom), 4'($urandom));
        end
        for (int n = 0; n < 4; n++) step(1'b0, 2'd0, '0, 4'b1111);
        chk("final_idle", DW'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
